dcache_ctrl: RTL and testbench

- Data-cache responder for the MEM stage; services the MemRead/MemWrite requests that the main decoder raises on load/store opcodes.
- Direct-mapped, write-back, write-allocate cache with 32-bit CPU words and 256-bit lines; tag, valid, dirty and data arrays are internal.
- Sits between the MEM-stage pipeline register and the off-chip data memory. Stalls the whole pipeline on a miss until the line is resident.

---
 rtl/dcache_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache for the MEM stage.
// 16 x 256-bit lines, 32-bit CPU words; stalls the pipeline until a missing line is resident.
module dcache_ctrl #(
    parameter int unsigned INDEX_W = 4,
    parameter int unsigned TAG_W   = 23
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [31:0]         cpu_addr_i,
    input  logic [31:0]         cpu_data_i,
    input  logic                cpu_MemRead_i,
    input  logic                cpu_MemWrite_i,
    output logic [31:0]         cpu_data_o,
    output logic                cpu_stall_o,
    input  logic [255:0]        mem_data_i,
    input  logic                mem_ack_i,
    output logic [31:0]         mem_addr_o,
    output logic [255:0]        mem_data_o,
    output logic                mem_enable_o,
    output logic                mem_write_o
);
    localparam int unsigned OFF_W  = 5;
    localparam int unsigned WSEL_W = 3;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned LINE_W = 256;
    localparam int unsigned LINES  = 1 << INDEX_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WB_REQ = 2'd1,
        RD_REQ = 2'd2,
        REFILL = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [INDEX_W-1:0]  miss_idx_q, miss_idx_d;
    logic [TAG_W-1:0]    miss_tag_q, miss_tag_d;
    logic [LINE_W-1:0]   refill_q, refill_d;
    logic                mem_enable_q, mem_enable_d;
    logic                mem_write_q, mem_write_d;
    logic [31:0]         mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0]   mem_data_q, mem_data_d;
    logic [LINES-1:0]    valid_q, valid_d;
    logic [LINES-1:0]    dirty_q, dirty_d;
    logic [LINE_W-1:0]   data_q [LINES];
    logic [LINE_W-1:0]   data_d [LINES];
    logic [TAG_W-1:0]    tag_q [LINES];
    logic [TAG_W-1:0]    tag_d [LINES];

    logic [INDEX_W-1:0]  idx_c;
    logic [TAG_W-1:0]    tag_c;
    logic [WSEL_W-1:0]   wsel_c;
    logic [7:0]          wbase_c;
    logic [1:0]          unused_c;
    logic                req_c;
    logic                store_c;
    logic                load_c;
    logic                hit_c;
    logic                idle_hit_c;
    logic [LINE_W-1:0]   line_c;
    logic [WORD_W-1:0]   rd_word_c;

    // Address decode; byte-within-word bits are not used (word accesses only)
    assign idx_c    = cpu_addr_i[OFF_W +: INDEX_W];
    assign tag_c    = cpu_addr_i[OFF_W + INDEX_W +: TAG_W];
    assign wsel_c   = cpu_addr_i[2 +: WSEL_W];
    assign wbase_c  = {wsel_c, 5'd0};
    assign unused_c = cpu_addr_i[1:0];

    assign req_c      = cpu_MemRead_i | cpu_MemWrite_i;
    assign store_c    = cpu_MemWrite_i;
    assign load_c     = cpu_MemRead_i & ~cpu_MemWrite_i;
    assign hit_c      = req_c & valid_q[idx_c] & (tag_q[idx_c] == tag_c);
    assign idle_hit_c = (state_q == IDLE) & hit_c;
    assign line_c     = data_q[idx_c];
    assign rd_word_c  = line_c[wbase_c +: WORD_W];

    // Stall and load data are combinational so a hit costs no cycle
    assign cpu_stall_o = req_c & ~idle_hit_c;
    assign cpu_data_o  = (idle_hit_c & load_c) ? rd_word_c : '0;

    assign mem_enable_o = mem_enable_q;
    assign mem_write_o  = mem_write_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;

    // Next-state, memory-request and array-update logic
    always_comb begin
        state_d      = state_q;
        miss_idx_d   = miss_idx_q;
        miss_tag_d   = miss_tag_q;
        refill_d     = refill_q;
        mem_enable_d = mem_enable_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        data_d       = data_q;
        tag_d        = tag_q;

        case (state_q)
            IDLE: begin
                if (idle_hit_c && store_c) begin
                    data_d[idx_c][wbase_c +: WORD_W] = cpu_data_i;
                    dirty_d[idx_c]                   = 1'b1;
                end else if (req_c && !hit_c) begin
                    miss_idx_d   = idx_c;
                    miss_tag_d   = tag_c;
                    mem_enable_d = 1'b1;
                    if (valid_q[idx_c] && dirty_q[idx_c]) begin
                        state_d     = WB_REQ;
                        mem_write_d = 1'b1;
                        mem_addr_d  = {tag_q[idx_c], idx_c, OFF_W'(0)};
                        mem_data_d  = line_c;
                    end else begin
                        state_d     = RD_REQ;
                        mem_write_d = 1'b0;
                        mem_addr_d  = {tag_c, idx_c, OFF_W'(0)};
                    end
                end
            end
            WB_REQ: begin
                if (mem_ack_i) begin
                    dirty_d[miss_idx_q] = 1'b0;
                    state_d             = RD_REQ;
                    mem_write_d         = 1'b0;
                    mem_addr_d          = {miss_tag_q, miss_idx_q, OFF_W'(0)};
                end
            end
            RD_REQ: begin
                if (mem_ack_i) begin
                    refill_d     = mem_data_i;
                    state_d      = REFILL;
                    mem_enable_d = 1'b0;
                    mem_write_d  = 1'b0;
                end
            end
            REFILL: begin
                data_d[miss_idx_q]  = refill_q;
                tag_d[miss_idx_q]   = miss_tag_q;
                valid_d[miss_idx_q] = 1'b1;
                dirty_d[miss_idx_q] = 1'b0;
                state_d             = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state and memory interface registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            miss_idx_q   <= '0;
            miss_tag_q   <= '0;
            refill_q     <= '0;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            valid_q      <= '0;
            dirty_q      <= '0;
        end else begin
            state_q      <= state_d;
            miss_idx_q   <= miss_idx_d;
            miss_tag_q   <= miss_tag_d;
            refill_q     <= refill_d;
            mem_enable_q <= mem_enable_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
        end
    end

    // Tag and data storage carry no reset; valid bits qualify them
    always_ff @(posedge clk_i) begin
        data_q <= data_d;
        tag_q  <= tag_d;
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Randomised and directed bench for dcache_ctrl against a flat-memory reference model.
module tb_dcache_ctrl;
    logic         clk_i;
    logic         rst_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_data_i;
    logic         cpu_MemRead_i;
    logic         cpu_MemWrite_i;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic         mem_enable_o;
    logic         mem_write_o;

    int checks   = 0;
    int failures = 0;

    // Architectural view (latest stored value) and off-chip memory contents, word addressed
    logic [31:0] arch [logic [29:0]];
    logic [31:0] back [logic [29:0]];
    // Which line each set holds, and whether it differs from memory
    logic        m_valid [16];
    logic        m_dirty [16];
    logic [22:0] m_tag   [16];

    dcache_ctrl dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .cpu_addr_i     (cpu_addr_i),
        .cpu_data_i     (cpu_data_i),
        .cpu_MemRead_i  (cpu_MemRead_i),
        .cpu_MemWrite_i (cpu_MemWrite_i),
        .cpu_data_o     (cpu_data_o),
        .cpu_stall_o    (cpu_stall_o),
        .mem_data_i     (mem_data_i),
        .mem_ack_i      (mem_ack_i),
        .mem_addr_o     (mem_addr_o),
        .mem_data_o     (mem_data_o),
        .mem_enable_o   (mem_enable_o),
        .mem_write_o    (mem_write_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] init_word(input logic [29:0] wa);
        return (32'(wa) * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
    endfunction

    function automatic logic [31:0] arch_rd(input logic [29:0] wa);
        return arch.exists(wa) ? arch[wa] : init_word(wa);
    endfunction

    function automatic logic [31:0] back_rd(input logic [29:0] wa);
        return back.exists(wa) ? back[wa] : init_word(wa);
    endfunction

    function automatic logic [255:0] arch_line(input logic [31:0] la);
        logic [255:0] l;
        l = '0;
        for (int w = 0; w < 8; w++) l = {arch_rd({la[31:5], 3'(w)}), l[255:32]};
        return l;
    endfunction

    function automatic logic [255:0] back_line(input logic [31:0] la);
        logic [255:0] l;
        l = '0;
        for (int w = 0; w < 8; w++) l = {back_rd({la[31:5], 3'(w)}), l[255:32]};
        return l;
    endfunction

    function automatic logic [255:0] rnd_line();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = '0;
        end
        arch = back;
    endtask

    // One CPU request from issue to completion, playing the memory with random latency
    task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic rd, input logic wr);
        logic [3:0]  idx;
        logic [22:0] tg;
        logic [31:0] la;
        logic [31:0] old_la;
        logic        hit;
        int          lat;
        idx = a[8:5];
        tg  = a[31:9];
        la  = {a[31:5], 5'd0};
        cpu_addr_i     = a;
        cpu_data_i     = wd;
        cpu_MemRead_i  = rd;
        cpu_MemWrite_i = wr;
        hit = m_valid[idx] && (m_tag[idx] == tg);
        if (!hit) begin
            @(negedge clk_i);
            chk("miss_stall", cpu_stall_o, 1'b1);
            @(posedge clk_i); #1;
            if (m_valid[idx] && m_dirty[idx]) begin
                old_la = {m_tag[idx], idx, 5'd0};
                lat = int'($urandom_range(0, 3));
                repeat (lat) begin
                    @(negedge clk_i);
                    chk("wb_wait_en", mem_enable_o, 1'b1);
                    chk("wb_wait_addr", mem_addr_o, old_la);
                    chk("wb_wait_stall", cpu_stall_o, 1'b1);
                    @(posedge clk_i); #1;
                end
                mem_ack_i = 1'b1;
                @(negedge clk_i);
                chk("wb_en", mem_enable_o, 1'b1);
                chk("wb_write", mem_write_o, 1'b1);
                chk("wb_addr", mem_addr_o, old_la);
                chk("wb_data", mem_data_o, arch_line(old_la));
                for (int w = 0; w < 8; w++) back[{old_la[31:5], 3'(w)}] = arch_rd({old_la[31:5], 3'(w)});
                @(posedge clk_i); #1;
                mem_ack_i = 1'b0;
                m_dirty[idx] = 1'b0;
            end
            lat = int'($urandom_range(0, 3));
            repeat (lat) begin
                @(negedge clk_i);
                chk("rd_wait_en", mem_enable_o, 1'b1);
                chk("rd_wait_write", mem_write_o, 1'b0);
                chk("rd_wait_addr", mem_addr_o, la);
                @(posedge clk_i); #1;
            end
            mem_ack_i  = 1'b1;
            mem_data_i = back_line(la);
            @(negedge clk_i);
            chk("rd_en", mem_enable_o, 1'b1);
            chk("rd_write", mem_write_o, 1'b0);
            chk("rd_addr", mem_addr_o, la);
            chk("rd_stall", cpu_stall_o, 1'b1);
            @(posedge clk_i); #1;
            mem_ack_i  = 1'b0;
            mem_data_i = rnd_line();
            @(negedge clk_i);
            chk("refill_stall", cpu_stall_o, 1'b1);
            chk("refill_en", mem_enable_o, 1'b0);
            @(posedge clk_i); #1;
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
            m_dirty[idx] = 1'b0;
        end
        @(negedge clk_i);
        chk("hit_stall", cpu_stall_o, 1'b0);
        chk("hit_no_mem", mem_enable_o, 1'b0);
        if (wr) chk("store_data_o", cpu_data_o, 32'd0);
        else    chk("load_data", cpu_data_o, arch_rd(a[31:2]));
        @(posedge clk_i); #1;
        if (wr) begin
            arch[a[31:2]] = wd;
            m_dirty[idx]  = 1'b1;
        end
    endtask

    initial begin
        rst_i          = 1'b0;
        cpu_addr_i     = '0;
        cpu_data_i     = '0;
        cpu_MemRead_i  = 1'b0;
        cpu_MemWrite_i = 1'b0;
        mem_data_i     = '0;
        mem_ack_i      = 1'b0;
        model_reset();

        // Reset values
        #12;
        chk("rst_stall", cpu_stall_o, 1'b0);
        chk("rst_en", mem_enable_o, 1'b0);
        chk("rst_write", mem_write_o, 1'b0);
        chk("rst_addr", mem_addr_o, 32'd0);
        chk("rst_mdata", mem_data_o, 256'd0);
        chk("rst_cdata", cpu_data_o, 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b1;

        // Cold miss refill, then zero-latency hit on another word of the line
        back[30'h48 >> 2] = 32'hDEAD_BEEF;
        arch[30'h48 >> 2] = 32'hDEAD_BEEF;
        access(32'h0000_0048, 32'd0, 1'b1, 1'b0);
        access(32'h0000_0044, 32'd0, 1'b1, 1'b0);

        // Store hit then dirty eviction of the same set
        access(32'h0000_0040, 32'h1234_5678, 1'b0, 1'b1);
        access(32'h0000_0240, 32'd0, 1'b1, 1'b0);

        // Clean eviction, then simultaneous read/write acts as a store
        access(32'h0000_0440, 32'd0, 1'b1, 1'b0);
        access(32'h0000_0440, 32'hCAFE_F00D, 1'b1, 1'b1);
        access(32'h0000_0440, 32'd0, 1'b1, 1'b0);
        access(32'h0000_0040, 32'd0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a refill
        cpu_addr_i    = 32'h0000_0640;
        cpu_MemRead_i = 1'b1;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("pre_rst_en", mem_enable_o, 1'b1);
        #2;
        rst_i          = 1'b0;
        cpu_MemRead_i  = 1'b0;
        cpu_MemWrite_i = 1'b0;
        #1;
        chk("async_rst_en", mem_enable_o, 1'b0);
        chk("async_rst_stall", cpu_stall_o, 1'b0);
        chk("async_rst_addr", mem_addr_o, 32'd0);
        model_reset();
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        access(32'h0000_0040, 32'd0, 1'b1, 1'b0);

        // Random mix over four tags to force hits, clean and dirty evictions
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            int          kind;
            a    = {23'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                    3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            kind = int'($urandom_range(0, 2));
            case (kind)
                0:       access(a, $urandom(), 1'b1, 1'b0);
                1:       access(a, $urandom(), 1'b0, 1'b1);
                default: access(a, $urandom(), 1'b1, 1'b1);
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
